// File: rtl/pc_sequencer_if.sv
// Purpose: bundles the instruction-memory, datapath and ACB-control signals of pc_sequencer.
// Latency: none; this is wiring only.
// Backpressure: none; instr_valid is a one-way strobe and the sequencer never stalls the source.
//
// Ports:
//   instr, instr_valid, zero                       : from instruction memory / datapath
//   sel_addr, address_j, label, pc_shadow          : to / about the ACB program counter
//   ir, ir_load, exec_valid, halted, fault, wrap_flag : instruction register and status
interface pc_sequencer_if #(
   parameter int INSTR_W = 16
);
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               zero;
   logic [1:0]         sel_addr;
   logic [7:0]         address_j;
   logic [7:0]         label;
   logic [7:0]         pc_shadow;
   logic [INSTR_W-1:0] ir;
   logic               ir_load;
   logic               exec_valid;
   logic               halted;
   logic               fault;
   logic               wrap_flag;

   // Environment side: instruction source and datapath flag, observes the sequencer.
   modport master (
      output instr, instr_valid, zero,
      input  sel_addr, address_j, label, pc_shadow, ir, ir_load,
             exec_valid, halted, fault, wrap_flag
   );

   // Sequencer side.
   modport slave (
      input  instr, instr_valid, zero,
      output sel_addr, address_j, label, pc_shadow, ir, ir_load,
             exec_valid, halted, fault, wrap_flag
   );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose: fetch/branch sequencer driving the ACB selAddr/label/addressJ controls and tracking a shadow PC.
// Latency: instruction latched on the FETCH edge, executed the next cycle; ACB controls are combinational.
// Backpressure: none; instr_valid is accepted only in FETCH and ignored elsewhere.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : pc_sequencer_if.slave (instr/instr_valid/zero in; ACB controls, ir and status out)
module pc_sequencer #(
   parameter int INSTR_W       = 16,
   parameter int FETCH_TIMEOUT = 15,
   parameter int TRAP_ON_WRAP  = 1
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      RST_S   = 3'd0,
      FETCH   = 3'd1,
      EXECUTE = 3'd2,
      HALT    = 3'd3,
      FAULT   = 3'd4
   } state_t;

   state_t             state;
   logic [7:0]         pcShadow;
   logic [7:0]         fetchCnt;
   logic [INSTR_W-1:0] irReg;
   logic               wrapReg;

   logic [3:0]         opcode;
   logic [7:0]         imm;
   logic               takeBranch;
   logic [8:0]         nextPc;
   logic [7:0]         cntNext;
   logic [1:0]         selAddr;
   logic [7:0]         addressJ;
   logic [7:0]         labelOut;

   assign opcode  = irReg[INSTR_W-1 -: 4];
   assign imm     = irReg[7:0];
   assign cntNext = fetchCnt + 8'd1;

   // zero is only looked at for the two conditional branches.
   always_comb begin
      takeBranch = 1'b0;
      if (opcode == 4'hC)
         takeBranch = bus.zero;
      else if (opcode == 4'hD)
         takeBranch = ~bus.zero;
   end

   // 9-bit next PC; bit 8 flags a wrap past 0xFF. A jump target is absolute and never wraps.
   always_comb begin
      nextPc = {1'b0, pcShadow} + 9'd1;
      if (opcode == 4'hE)
         nextPc = {1'b0, imm};
      else if (takeBranch)
         nextPc = {1'b0, pcShadow} + {1'b0, imm};
   end

   // ACB controls must settle before the edge that loads the ACB PC.
   // The ACB has no hold, so holding means jumping to the shadow copy.
   always_comb begin
      selAddr  = 2'd0;
      addressJ = 8'h00;
      labelOut = 8'h00;
      case (state)
         RST_S: begin
            selAddr = 2'd0;
         end
         EXECUTE: begin
            if (opcode == 4'hF) begin
               selAddr  = 2'd3;
               addressJ = pcShadow;
            end else if (opcode == 4'hE) begin
               selAddr  = 2'd3;
               addressJ = imm;
            end else if (takeBranch) begin
               selAddr  = 2'd2;
               labelOut = imm;
            end else begin
               selAddr = 2'd1;
            end
         end
         default: begin
            selAddr  = 2'd3;
            addressJ = pcShadow;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RST_S;
         pcShadow <= 8'h00;
         fetchCnt <= 8'h00;
         irReg    <= '0;
         wrapReg  <= 1'b0;
      end else begin
         case (state)
            RST_S: begin
               pcShadow <= 8'h00;
               state    <= FETCH;
            end
            FETCH: begin
               if (bus.instr_valid) begin
                  irReg    <= bus.instr;
                  fetchCnt <= 8'h00;
                  state    <= EXECUTE;
               end else begin
                  fetchCnt <= cntNext;
                  if (cntNext == 8'(FETCH_TIMEOUT))
                     state <= FAULT;
               end
            end
            EXECUTE: begin
               if (opcode == 4'hF) begin
                  state <= HALT;
               end else begin
                  // Commit even on a wrap so the shadow keeps tracking the ACB PC.
                  pcShadow <= nextPc[7:0];
                  if (nextPc[8]) begin
                     wrapReg <= 1'b1;
                     state   <= (TRAP_ON_WRAP != 0) ? FAULT : FETCH;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            HALT:    state <= HALT;
            FAULT:   state <= FAULT;
            default: state <= FAULT;
         endcase
      end
   end

   assign bus.sel_addr   = selAddr;
   assign bus.address_j  = addressJ;
   assign bus.label      = labelOut;
   assign bus.pc_shadow  = pcShadow;
   assign bus.ir         = irReg;
   assign bus.ir_load    = (state == FETCH) && bus.instr_valid;
   assign bus.exec_valid = (state == EXECUTE);
   assign bus.halted     = (state == HALT);
   assign bus.fault      = (state == FAULT);
   assign bus.wrap_flag  = wrapReg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: self-checking bench for pc_sequencer with a trapping and a non-trapping instance.
// Latency: one FETCH edge to latch, one EXECUTE cycle; checks sample #1 after edges or mid-cycle.
// Backpressure: none; stimulus is driven at falling edges.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic        instrValid = 1'b0;
   logic        zero = 1'b0;

   always #5 clk = ~clk;

   pc_sequencer_if #(.INSTR_W(16)) busA ();
   pc_sequencer_if #(.INSTR_W(16)) busB ();

   assign busA.instr       = instr;
   assign busA.instr_valid = instrValid;
   assign busA.zero        = zero;
   assign busB.instr       = instr;
   assign busB.instr_valid = instrValid;
   assign busB.zero        = zero;

   pc_sequencer #(.INSTR_W(16), .FETCH_TIMEOUT(15), .TRAP_ON_WRAP(1)) dutA (
      .clk (clk),
      .rst (rst),
      .bus (busA.slave)
   );

   pc_sequencer #(.INSTR_W(16), .FETCH_TIMEOUT(15), .TRAP_ON_WRAP(0)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (busB.slave)
   );

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [1:0] sel;
      logic [7:0] lbl;
      logic [7:0] aj;
      logic [7:0] pc;
      logic       wrap;
      logic       flt;
      logic       hlt;
   } exp_t;

   typedef struct {
      logic [7:0]  startPc;
      logic [15:0] ins;
      logic        z;
      exp_t        e;
   } vec_t;

   exp_t sbQ[$];
   vec_t vecs[12];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s", name);
   endtask

   // Holds reset for two cycles, releases mid-cycle, checks the single RST_S cycle,
   // and returns at a falling edge in the first FETCH cycle.
   task automatic doReset();
      rst = 1'b0;
      instrValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_s.sel", 16'(busA.sel_addr), 16'd0);
      @(posedge clk);
      #1;
      chk("fetch.sel", 16'(busA.sel_addr), 16'd3);
      @(negedge clk);
   endtask

   // Issues one instruction from FETCH; expected EXECUTE outputs come from the scoreboard.
   task automatic doInstr(input logic [15:0] ins, input logic z, input string tag);
      exp_t e;
      int   waitCyc;
      instr = ins;
      zero = z;
      instrValid = 1'b1;
      #1;
      chk({tag, ".ir_load"}, 16'(busA.ir_load), 16'd1);
      @(posedge clk);
      #1;
      instrValid = 1'b0;
      waitCyc = 0;
      while (busA.exec_valid !== 1'b1 && waitCyc < 4) begin
         @(posedge clk);
         #1;
         waitCyc++;
      end
      if (busA.exec_valid !== 1'b1) begin
         failNow({tag, ".exec_valid_timeout"});
         if (sbQ.size() > 0) void'(sbQ.pop_front());
         @(negedge clk);
         return;
      end
      if (sbQ.size() == 0) begin
         failNow({tag, ".scoreboard_empty"});
         @(negedge clk);
         return;
      end
      e = sbQ.pop_front();
      chk({tag, ".ir"}, busA.ir, ins);
      chk({tag, ".sel"}, 16'(busA.sel_addr), 16'(e.sel));
      if (e.sel == 2'd2) chk({tag, ".label"}, 16'(busA.label), 16'(e.lbl));
      if (e.sel == 2'd3) chk({tag, ".address_j"}, 16'(busA.address_j), 16'(e.aj));
      @(posedge clk);
      #1;
      chk({tag, ".pc"}, 16'(busA.pc_shadow), 16'(e.pc));
      chk({tag, ".wrap"}, 16'(busA.wrap_flag), 16'(e.wrap));
      chk({tag, ".fault"}, 16'(busA.fault), 16'(e.flt));
      chk({tag, ".halted"}, 16'(busA.halted), 16'(e.hlt));
      chk({tag, ".nt.pc"}, 16'(busB.pc_shadow), 16'(e.pc));
      chk({tag, ".nt.wrap"}, 16'(busB.wrap_flag), 16'(e.wrap));
      chk({tag, ".nt.fault"}, 16'(busB.fault), 16'd0);
      @(negedge clk);
   endtask

   task automatic pushJump(input logic [7:0] tgt);
      sbQ.push_back('{sel: 2'd3, lbl: 8'h00, aj: tgt, pc: tgt, wrap: 1'b0, flt: 1'b0, hlt: 1'b0});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      //             startPc  instr     z      sel    label  addrJ  pc     wrap  fault halt
      vecs[0]  = '{8'h05, 16'h1234, 1'b0, '{2'd1, 8'h00, 8'h00, 8'h06, 1'b0, 1'b0, 1'b0}};
      vecs[1]  = '{8'h10, 16'hC003, 1'b1, '{2'd2, 8'h03, 8'h00, 8'h13, 1'b0, 1'b0, 1'b0}};
      vecs[2]  = '{8'h10, 16'hC003, 1'b0, '{2'd1, 8'h00, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0}};
      vecs[3]  = '{8'h10, 16'hD003, 1'b0, '{2'd2, 8'h03, 8'h00, 8'h13, 1'b0, 1'b0, 1'b0}};
      vecs[4]  = '{8'h10, 16'hD003, 1'b1, '{2'd1, 8'h00, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0}};
      vecs[5]  = '{8'h00, 16'hE0A5, 1'b0, '{2'd3, 8'h00, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0}};
      vecs[6]  = '{8'hFF, 16'h1234, 1'b0, '{2'd1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0}};
      vecs[7]  = '{8'hF0, 16'hC020, 1'b1, '{2'd2, 8'h20, 8'h00, 8'h10, 1'b1, 1'b1, 1'b0}};
      vecs[8]  = '{8'hFF, 16'hE0FF, 1'b1, '{2'd3, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0}};
      vecs[9]  = '{8'h20, 16'hB0FF, 1'b1, '{2'd1, 8'h00, 8'h00, 8'h21, 1'b0, 1'b0, 1'b0}};
      vecs[10] = '{8'h30, 16'hF000, 1'b0, '{2'd3, 8'h00, 8'h30, 8'h30, 1'b0, 1'b0, 1'b1}};
      vecs[11] = '{8'hFE, 16'h0000, 1'b0, '{2'd1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0}};

      // Reset values while rst is held low.
      @(negedge clk);
      @(negedge clk);
      chk("rst.sel", 16'(busA.sel_addr), 16'd0);
      chk("rst.address_j", 16'(busA.address_j), 16'd0);
      chk("rst.label", 16'(busA.label), 16'd0);
      chk("rst.pc", 16'(busA.pc_shadow), 16'd0);
      chk("rst.ir", busA.ir, 16'd0);
      chk("rst.ir_load", 16'(busA.ir_load), 16'd0);
      chk("rst.exec_valid", 16'(busA.exec_valid), 16'd0);
      chk("rst.halted", 16'(busA.halted), 16'd0);
      chk("rst.fault", 16'(busA.fault), 16'd0);
      chk("rst.wrap", 16'(busA.wrap_flag), 16'd0);
      doReset();
      chk("fetch0.address_j", 16'(busA.address_j), 16'd0);
      chk("fetch0.label", 16'(busA.label), 16'd0);

      // Table: jump to the start PC, then execute the vector instruction.
      for (int i = 0; i < 12; i++) begin
         doReset();
         pushJump(vecs[i].startPc);
         doInstr(16'hE000 | {8'h00, vecs[i].startPc}, 1'b0, $sformatf("v%0d.jmp", i));
         sbQ.push_back(vecs[i].e);
         doInstr(vecs[i].ins, vecs[i].z, $sformatf("v%0d", i));
      end

      // HALT freezes the PC and ignores further valid instructions.
      doReset();
      pushJump(8'hA5);
      doInstr(16'hE0A5, 1'b0, "h.jmp");
      sbQ.push_back('{sel: 2'd3, lbl: 8'h00, aj: 8'hA5, pc: 8'hA5, wrap: 1'b0, flt: 1'b0, hlt: 1'b1});
      doInstr(16'hF000, 1'b0, "h.halt");
      instr = 16'hE011;
      instrValid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("halt.halted", 16'(busA.halted), 16'd1);
         chk("halt.address_j", 16'(busA.address_j), 16'hA5);
         chk("halt.pc", 16'(busA.pc_shadow), 16'hA5);
         chk("halt.ir_load", 16'(busA.ir_load), 16'd0);
         chk("halt.exec_valid", 16'(busA.exec_valid), 16'd0);
      end
      instrValid = 1'b0;

      // Fetch timeout: 15 idle FETCH cycles, fault on the 16th.
      doReset();
      for (int k = 1; k <= 15; k++) begin
         chk($sformatf("to.fault%0d", k), 16'(busA.fault), 16'd0);
         chk($sformatf("to.sel%0d", k), 16'(busA.sel_addr), 16'd3);
         @(negedge clk);
      end
      chk("to.fault16", 16'(busA.fault), 16'd1);
      chk("to.address_j16", 16'(busA.address_j), 16'd0);

      // Just under the timeout: a valid on the 15th cycle is accepted and clears the counter.
      doReset();
      repeat (14) @(negedge clk);
      chk("to14.fault", 16'(busA.fault), 16'd0);
      sbQ.push_back('{sel: 2'd1, lbl: 8'h00, aj: 8'h00, pc: 8'h01, wrap: 1'b0, flt: 1'b0, hlt: 1'b0});
      doInstr(16'h0001, 1'b0, "to14.seq");
      repeat (14) @(negedge clk);
      chk("to14.after.fault", 16'(busA.fault), 16'd0);
      chk("to14.after.sel", 16'(busA.sel_addr), 16'd3);

      // Asynchronous reset in the middle of EXECUTE.
      doReset();
      pushJump(8'h40);
      doInstr(16'hE040, 1'b0, "ar.jmp");
      instr = 16'hC005;
      zero = 1'b1;
      instrValid = 1'b1;
      @(posedge clk);
      #1;
      instrValid = 1'b0;
      chk("ar.exec_valid", 16'(busA.exec_valid), 16'd1);
      chk("ar.sel_exec", 16'(busA.sel_addr), 16'd2);
      #1;
      rst = 1'b0;
      #1;
      chk("ar.sel", 16'(busA.sel_addr), 16'd0);
      chk("ar.label", 16'(busA.label), 16'd0);
      chk("ar.address_j", 16'(busA.address_j), 16'd0);
      chk("ar.exec_valid0", 16'(busA.exec_valid), 16'd0);
      chk("ar.pc", 16'(busA.pc_shadow), 16'd0);
      chk("ar.ir", busA.ir, 16'd0);
      chk("ar.halted", 16'(busA.halted), 16'd0);
      chk("ar.fault", 16'(busA.fault), 16'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      if (sbQ.size() != 0) failNow("scoreboard_leftover");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/branch sequencer directly upstream of the address calculation block (ACB).
- Every cycle it drives the ACB's selAddr, label and addressJ inputs so the program counter resets, holds, increments, branches or jumps.
- The ACB PC loads on every clock edge and has no hold option. The sequencer therefore keeps a shadow copy of the PC and holds the PC by issuing a jump to that copy (sel=3).
- Instructions arrive from instruction memory with a valid strobe. The sequencer latches each one, decodes its opcode and resolves branches against the datapath zero flag.

Parameters:
- INSTR_W, 16: instruction width; opcode = instr[INSTR_W-1:INSTR_W-4], immediate = instr[7:0].
- FETCH_TIMEOUT, 15: number of consecutive FETCH cycles without instr_valid that forces FAULT; range 1..255.
- TRAP_ON_WRAP, 1: 1 = a PC wrap past 0xFF enters FAULT; 0 = a wrap only sets wrap_flag.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- instr  in  INSTR_W  instruction word from instruction memory.
- instr_valid  in  1  instr is valid this cycle.
- zero  in  1  datapath zero flag, sampled in EXECUTE.
- sel_addr  out  2  to ACB selAddr: 0 = address 0, 1 = PC+1, 2 = PC+label, 3 = addressJ.
- address_j  out  8  to ACB addressJ.
- label  out  8  to ACB label.
- pc_shadow  out  8  PC value the ACB holds this cycle.
- ir  out  INSTR_W  latched instruction register.
- ir_load  out  1  one-cycle pulse when ir captures instr.
- exec_valid  out  1  high during EXECUTE; ir is valid for the datapath.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- wrap_flag  out  1  sticky: a taken next-PC overflowed 8 bits.

Behaviour:
- States: RST_S, FETCH, EXECUTE, HALT, FAULT.
- Reset (rst=0, asynchronous):
  - state=RST_S, pc_shadow=0, ir=0, fetch counter=0, wrap_flag=0.
  - Outputs: sel_addr=0, address_j=0, label=0; ir_load, exec_valid, halted and fault all 0.
- Reset mid-operation aborts immediately; no partial update survives.
- RST_S: sel_addr=0 (PC<=0). Next state FETCH unconditionally; RST_S lasts exactly one cycle after rst deasserts.
- FETCH:
  - Drive sel_addr=3, address_j=pc_shadow, label=0 (PC holds).
  - If instr_valid=1: ir<=instr, ir_load=1, counter<=0, next EXECUTE.
  - Otherwise: counter<=counter+1. If counter+1 reaches FETCH_TIMEOUT, next FAULT.
- EXECUTE: exec_valid=1; exactly one cycle; decode ir opcode.
  - 0x0-0xB: sel_addr=1; next_pc=pc_shadow+1.
  - 0xC BEQ: if zero=1, sel_addr=2, label=ir[7:0], next_pc=pc_shadow+ir[7:0]; else treated as sequential.
  - 0xD BNE: same as BEQ with the zero condition inverted.
  - 0xE J: sel_addr=3, address_j=ir[7:0], next_pc=ir[7:0]; never sets a wrap.
  - 0xF HALT: sel_addr=3, address_j=pc_shadow; next HALT; pc_shadow unchanged.
  - Otherwise: pc_shadow<=next_pc[7:0], next FETCH.
- Arithmetic:
  - Unsigned 9-bit sum; bit 8 = wrap.
  - On a wrap: wrap_flag<=1. If TRAP_ON_WRAP=1, next FAULT, with the wrapped pc_shadow still committed to match the ACB PC. If TRAP_ON_WRAP=0, next FETCH.
- Output timing:
  - sel_addr, label and address_j are combinational from state, ir and zero, and must settle before the same clock edge that updates the ACB PC.
  - The ACB therefore loads exactly next_pc on the edge leaving EXECUTE.
- HALT/FAULT:
  - sel_addr=3, address_j=pc_shadow (PC frozen).
  - instr_valid is ignored; the only exit is rst.
- Invariant: after every edge, pc_shadow equals the ACB PC.
- A non-branch opcode never uses zero.

Test Plan:
- Reset release: instr_valid held 0 -> RST_S 1 cycle with sel_addr=0, then FETCH with sel_addr=3, address_j=0x00.
- Sequential: instr=0x1234 valid at pc=0x05 -> ir_load=1, next cycle EXECUTE sel_addr=1, then pc_shadow=0x06.
- Branches at pc=0x10:
  - BEQ 0xC003 with zero=1 -> sel_addr=2, label=0x03, pc_shadow=0x13.
  - Same with zero=0 -> sel_addr=1, pc_shadow=0x11.
- Jump and halt:
  - J 0xE0A5 -> sel_addr=3, address_j=0xA5, pc_shadow=0xA5.
  - Then HALT 0xF000 -> halted=1; address_j stays 0xA5 forever, instr_valid ignored.
- Wrap:
  - pc=0xFF sequential, TRAP_ON_WRAP=1 -> pc_shadow=0x00, wrap_flag=1, fault=1.
  - With TRAP_ON_WRAP=0 -> wrap_flag=1, back to FETCH.
- Timeout and async reset:
  - instr_valid low for 15 cycles in FETCH -> fault=1 on the 16th cycle.
  - rst low mid-EXECUTE -> all outputs at reset values immediately, without waiting for a clock edge.
